// File: rtl/rr_priority_arbiter.sv
// -----------------------------------------------------------------------------
// rr_priority_arbiter
//
// Purpose:
//   N-way request arbiter that sits between a bank of requesters and one shared
//   resource. It supports two selection policies, chosen by `mode`:
//     - Fixed priority: the highest-index requester wins.
//     - Round-robin: the search runs downward from the most recently accepted
//       index and wraps around modulo N.
//   The grant is registered and offered with a valid/ready handshake. Once
//   presented, it stays frozen until the consumer accepts it.
//
// Parameters:
//   N      number of requesters (2..64)
//   IDX_W  width of grant_idx, derived from N
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   req    [N]    request vector, bit i = requester i wants the resource
//   mode          0 = fixed priority, 1 = round-robin
//   ready         consumer accepts the presented grant this cycle
//   grant_valid   a grant is presented
//   grant_idx     binary index of the granted requester
//   grant_onehot  one-hot form of grant_idx, all-zero when grant_valid = 0
//
// All outputs come straight from flops. There is no combinational path from
// req, mode or ready to any output.
// -----------------------------------------------------------------------------
module rr_priority_arbiter #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             mode,
    input  logic             ready,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic [N-1:0]     grant_onehot
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_reg;
    logic             valid_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [N-1:0]     onehot_reg;
    logic [IDX_W-1:0] last_idx_reg;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    logic accept;
    logic select_event;

    assign accept       = (state_reg == HOLD) && ready;
    // A new grant is computed whenever nothing is presented, or when the
    // presented grant is being accepted. A HOLD state with ready low freezes
    // everything.
    assign select_event = (state_reg == IDLE) || ready;

    // On an accept edge, the freshly accepted index already acts as the
    // round-robin pointer. This is what allows back-to-back grants.
    logic [IDX_W-1:0] ptr;
    assign ptr = accept ? idx_reg : last_idx_reg;

    // -------------------------------------------------------------------------
    // Round-robin split
    //
    // The search order is ptr-1 down to 0, then N-1 down to ptr. That order is
    // the same as:
    //   - the highest set bit among indices strictly below ptr, if there is one,
    //   - otherwise the highest set bit overall.
    // Fixed mode forces the "below" group to empty. This makes fixed mode the
    // same as round-robin with ptr = 0.
    // -------------------------------------------------------------------------
    logic [N-1:0] below_mask;
    logic [N-1:0] masked_req;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_below
            assign below_mask[gi] = (IDX_W'(gi) < ptr);
        end
    endgenerate

    assign masked_req = req & below_mask & {N{mode}};

    // -------------------------------------------------------------------------
    // Two highest-set-bit pickers, built as downward OR chains.
    // above_x[gi] is set when vector x has any set bit at an index above gi.
    // -------------------------------------------------------------------------
    logic [N-1:0] above_masked;
    logic [N-1:0] above_full;
    logic [N-1:0] win_masked;
    logic [N-1:0] win_full;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pick
            if (gi == N - 1) begin : g_top
                assign above_masked[gi] = 1'b0;
                assign above_full[gi]   = 1'b0;
            end else begin : g_chain
                assign above_masked[gi] = above_masked[gi+1] | masked_req[gi+1];
                assign above_full[gi]   = above_full[gi+1]   | req[gi+1];
            end
            assign win_masked[gi] = masked_req[gi] & ~above_masked[gi];
            assign win_full[gi]   = req[gi]        & ~above_full[gi];
        end
    endgenerate

    logic         any_req;
    logic [N-1:0] win_onehot;

    assign any_req    = |req;
    assign win_onehot = (|masked_req) ? win_masked : win_full;

    // One-hot to binary conversion. The input has at most one bit set, so
    // OR-ing the matching indices gives the encoded index.
    logic [IDX_W-1:0] win_idx;

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N; i++) begin
            win_idx = win_idx | (win_onehot[i] ? IDX_W'(i) : '0);
        end
    end

    // -------------------------------------------------------------------------
    // FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            valid_reg    <= 1'b0;
            idx_reg      <= '0;
            onehot_reg   <= '0;
            last_idx_reg <= '0;
        end else begin
            // The pointer update happens in the same edge as the next
            // selection. That selection already uses the new value via ptr.
            if (accept) begin
                last_idx_reg <= idx_reg;
            end

            case (state_reg)
                IDLE, HOLD: begin
                    if (select_event) begin
                        if (any_req) begin
                            state_reg  <= HOLD;
                            valid_reg  <= 1'b1;
                            idx_reg    <= win_idx;
                            onehot_reg <= win_onehot;
                        end else begin
                            state_reg  <= IDLE;
                            valid_reg  <= 1'b0;
                            idx_reg    <= '0;
                            onehot_reg <= '0;
                        end
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    valid_reg  <= 1'b0;
                    idx_reg    <= '0;
                    onehot_reg <= '0;
                end
            endcase
        end
    end

    assign grant_valid  = valid_reg;
    assign grant_idx    = idx_reg;
    assign grant_onehot = onehot_reg;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for rr_priority_arbiter with N = 8.
//
// Inputs are driven after the falling edge. Outputs are checked 1 time unit
// after the rising edge. A reference model steps once per rising edge, using
// the arbitration rules written as plain loops over the search order.
// -----------------------------------------------------------------------------
module tb_rr_priority_arbiter;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req;
    logic             mode;
    logic             ready;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic [N-1:0]     grant_onehot;

    int tests_run;
    int tests_failed;

    // Reference model state
    bit m_valid;
    int m_idx;
    int m_last;

    rr_priority_arbiter #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .mode         (mode),
        .ready        (ready),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arbitration rule. Returns the chosen index, or -1 if no request is set.
    function automatic int ref_pick(logic [N-1:0] r, bit m, int last);
        if (!m) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (r[i]) return i;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (((last - k) % N) + N) % N;
                if (r[c]) return c;
            end
        end
        return -1;
    endfunction

    // Advances the model by one rising clock edge.
    task automatic model_edge();
        if (!m_valid || ready) begin
            int p;
            if (m_valid && ready) m_last = m_idx;
            p = ref_pick(req, mode, m_last);
            if (p >= 0) begin
                m_valid = 1'b1;
                m_idx   = p;
            end else begin
                m_valid = 1'b0;
                m_idx   = 0;
            end
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_idx   = 0;
        m_last  = 0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compares all three outputs against the model.
    task automatic check_model(input string tag);
        logic [N-1:0] exp_oh;
        exp_oh = m_valid ? (8'd1 << m_idx) : 8'd0;
        check({tag, ".valid"},  64'(grant_valid),  64'(m_valid));
        check({tag, ".idx"},    64'(grant_idx),    64'(m_idx));
        check({tag, ".onehot"}, 64'(grant_onehot), 64'(exp_oh));
    endtask

    // Applies inputs, lets one rising edge pass, then checks against the model.
    // Returns at the next falling edge.
    task automatic cycle(input logic [N-1:0] r, input logic m, input logic rd, input string tag);
        req   = r;
        mode  = m;
        ready = rd;
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
        $display("[TB] %s req=%b mode=%0d ready=%0d -> valid=%0d idx=%0d onehot=%b",
                 tag, r, m, rd, grant_valid, grant_idx, grant_onehot);
        @(negedge clk);
    endtask

    // Asserts reset between edges, checks that the outputs clear before any
    // clock edge, and releases reset at the following falling edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check({tag, ".rst_valid"},  64'(grant_valid),  64'd0);
        check({tag, ".rst_idx"},    64'(grant_idx),    64'd0);
        check({tag, ".rst_onehot"}, 64'(grant_onehot), 64'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst   = 1'b0;
        req   = '0;
        mode  = 1'b0;
        ready = 1'b0;
        model_reset();

        // Power-on reset, asserted before the first clock edge
        #1;
        rst = 1'b1;
        #1;
        check("por.valid",  64'(grant_valid),  64'd0);
        check("por.idx",    64'(grant_idx),    64'd0);
        check("por.onehot", 64'(grant_onehot), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1. Fixed priority
        for (int k = 0; k < 4; k++) begin
            cycle(8'b1001_0010, 1'b0, 1'b1, "fixed_a");
            check("fixed_a.idx7", 64'(grant_idx), 64'd7);
        end
        cycle(8'b0001_1000, 1'b0, 1'b1, "fixed_b");
        check("fixed_b.idx4", 64'(grant_idx), 64'd4);

        // 2. Round-robin full load, starting from reset
        async_reset("rr_full");
        for (int k = 0; k < 9; k++) begin
            cycle(8'hFF, 1'b1, 1'b1, "rr_full");
            check("rr_full.seq", 64'(grant_idx), 64'(7 - (k % 8)));
        end

        // 3. Round-robin partial load: 4,3,4,3
        for (int k = 0; k < 4; k++) begin
            cycle(8'b0001_1000, 1'b1, 1'b1, "rr_part");
            check("rr_part.seq", 64'(grant_idx), (k % 2 == 0) ? 64'd4 : 64'd3);
        end
        cycle(8'b0001_1000, 1'b1, 1'b1, "rr_part");
        check("rr_part.idx4", 64'(grant_idx), 64'd4);

        // 4. Hold under backpressure while req and mode change
        for (int k = 0; k < 3; k++) begin
            cycle(8'h01, logic'(k % 2), 1'b0, "hold");
            check("hold.idx",    64'(grant_idx),    64'd4);
            check("hold.onehot", 64'(grant_onehot), 64'h10);
        end
        cycle(8'h01, 1'b0, 1'b1, "hold_rel");
        check("hold_rel.idx0", 64'(grant_idx), 64'd0);

        // 5. Empty request vector, then ready pulses while idle
        cycle(8'h00, 1'b1, 1'b1, "empty");
        check("empty.valid", 64'(grant_valid), 64'd0);
        for (int k = 0; k < 3; k++) cycle(8'h00, 1'b1, logic'(k % 2), "idle_rdy");
        // After index 6 is accepted, the next full load must grant 5
        cycle(8'h40, 1'b1, 1'b1, "empty_b");
        cycle(8'h00, 1'b1, 1'b1, "empty_c");
        for (int k = 0; k < 3; k++) cycle(8'h00, 1'b1, 1'b1, "idle_rdy2");
        cycle(8'hFF, 1'b1, 1'b1, "empty_d");
        check("empty_d.idx5", 64'(grant_idx), 64'd5);

        // 6. Asynchronous reset in the middle of a HOLD
        cycle(8'hFF, 1'b1, 1'b0, "pre_rst");
        check("pre_rst.valid", 64'(grant_valid), 64'd1);
        async_reset("mid_hold");
        cycle(8'hFF, 1'b1, 1'b1, "post_rst");
        check("post_rst.idx7", 64'(grant_idx), 64'd7);

        // Randomised traffic checked against the model
        for (int k = 0; k < 400; k++) begin
            logic [N-1:0] r;
            r = N'($urandom) & N'($urandom | $urandom);
            if ($urandom_range(0, 9) == 0) r = '0;
            if ($urandom_range(0, 79) == 0) begin
                async_reset("rand_rst");
            end
            cycle(r, logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) != 0), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rr_priority_arbiter.md
# rr_priority_arbiter

Parametrised N-way request arbiter with a registered grant and a valid/ready handshake on the output. It selects fixed priority (highest index wins) or round-robin per cycle via a mode input. The grant is held stable until the consumer accepts it. It sits between a bank of requesters and a single shared resource, and supersedes the purely combinational 8-input priority encoder.

## Interface
Parameters:
- N, default 8: number of requesters; legal range 2..64.
- IDX_W, default $clog2(N): width of grant_idx; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request vector; bit i = requester i wants the resource.
- mode  input  1  0 = fixed priority (highest index wins); 1 = round-robin.
- ready  input  1  consumer accepts the current grant this cycle.
- grant_valid  output  1  a grant is presented.
- grant_idx  output  IDX_W  binary index of granted requester.
- grant_onehot  output  N  one-hot form of grant_idx; all-zero when grant_valid=0.

## Operation
- Registered state:
  - grant_valid, grant_idx, grant_onehot.
  - last_idx (IDX_W), the index of the most recently accepted grant.
- Two-state FSM:
  - IDLE (grant_valid=0).
  - HOLD (grant_valid=1).
- Selection event: a clock edge where grant_valid=0, or where grant_valid=1 and ready=1 (accept).
  - On a selection event, the next grant is computed from the current req and mode.
  - If no req bit is set: go to IDLE, grant_valid=0, grant_onehot=0, grant_idx=0.
- Fixed mode (mode=0): select the highest-index set bit of req.
- Round-robin mode (mode=1): search order is last_idx-1, last_idx-2, …, 0, N-1, …, last_idx (descending, modulo N); select the first set bit.
  - With last_idx=0 this order equals fixed priority.
  - The just-served requester is lowest priority on the next search.
- Accept updates last_idx:
  - On accept, last_idx <= grant_idx in both modes.
  - The selection in the same edge uses the updated value, i.e. the accepted index. This gives back-to-back grants with no bubble.
- HOLD with ready=0: all outputs and last_idx frozen.
  - Holds even if req changes or the granted bit deasserts; the grant is sticky.
  - Holds even if mode changes.
- Mode change: takes effect at the next selection event only.
- Invariants:
  - grant_onehot == (grant_valid ? 1<<grant_idx : 0) at all times.
  - grant_idx is always < N.

## Timing
- Reset (async assert, outputs update without waiting for a clock edge):
  - grant_valid=0, grant_idx=0, grant_onehot=0, last_idx=0, FSM=IDLE.
  - Deassertion is sampled synchronously; the first selection happens at the first rising edge after release.
- Latency: req to grant_valid is 1 cycle. A req that is stable before edge k produces a grant visible after edge k.
- Throughput: one grant per cycle while ready=1 and req is non-zero.
- ready while grant_valid=0: ignored; last_idx unchanged.
- Simultaneous accept and a new req: the new req participates in the same-edge selection.
- Accept when req=0: go to IDLE next cycle; last_idx still updates.
- Reset mid-HOLD: grant dropped, no accept recorded, round-robin pointer returns to 0.
- No combinational path from req, mode or ready to any output.

## Test plan
All scenarios use N=8.
1. Fixed priority:
   - Stimulus: reset, mode=0, ready=1, req=8'b1001_0010.
   - Response: one edge later grant_valid=1, grant_idx=7, grant_onehot=8'h80; stays 7 every cycle.
   - Then req=8'b0001_1000: next cycle grant_idx=4.
2. Round-robin full load:
   - Stimulus: reset, mode=1, ready=1, req=8'hFF.
   - Response: grant_idx sequence 7,6,5,4,3,2,1,0,7 on consecutive cycles, grant_valid=1 throughout.
3. Round-robin partial load:
   - Stimulus: mode=1, ready=1, req=8'b0001_1000.
   - Response: grant_idx alternates 4,3,4,3; never grants an unrequested index.
4. Hold / backpressure:
   - Stimulus: grant_idx=4 presented, ready=0 for 3 cycles; meanwhile req changes to 8'h01 and mode toggles.
   - Response: grant_idx=4 and grant_onehot=8'h10 unchanged for all 3 cycles.
   - Then ready=1 for one edge: next cycle grant_idx=0.
5. Empty request vector:
   - Stimulus: req=8'h00, ready=1 after an accept.
   - Response: next cycle grant_valid=0, grant_idx=0, grant_onehot=0.
   - ready pulses while idle do not change the round-robin order; the next req=8'hFF yields the index below the last accepted one.
6. Async reset mid-HOLD:
   - Stimulus: assert rst between clock edges while grant_valid=1, ready=0.
   - Response: outputs go to 0 before the next edge.
   - After release with mode=1, req=8'hFF, ready=1: the first grant_idx is 7.
